// File: rtl/adio_rx.sv
// I2S-style ADC-path receiver: oversamples BCK/LRCK/ADCDAT and deserializes MSB-first L/R pairs.
// Optional peak meter on oPEAK is built only when ADIO_RX_PEAK_METER_EN is defined.
module adio_rx #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  iCLK_18_4,
  input  logic                  iRST,
  input  logic                  iAUD_BCK,
  input  logic                  iAUD_LRCK,
  input  logic                  iAUD_ADCDAT,
  input  logic                  iPEAK_CLR,
  output logic [DATA_WIDTH-1:0] oLEFT,
  output logic [DATA_WIDTH-1:0] oRIGHT,
  output logic                  oVALID,
  output logic                  oFRAME_ERR,
  output logic [DATA_WIDTH-1:0] oPEAK
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntFull = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {StSync, StShift, StWait} state_t;

  logic [SYNC_STAGES-1:0] r_bck_sync, r_lrck_sync, r_dat_sync;
  logic                   r_bck_prev;
  logic                   r_lrck_last, r_lrck_seen;
  state_t                 r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   r_chan, w_chan_nxt;
  logic                   r_done;
  logic [DATA_WIDTH-1:0]  r_hold;
  logic                   r_left_vld;

  logic w_bck, w_lrck, w_dat, w_bck_rise, w_lrck_chg, w_start, w_done, w_short, w_store;

  assign w_bck      = r_bck_sync[SYNC_STAGES-1];
  assign w_lrck     = r_lrck_sync[SYNC_STAGES-1];
  assign w_dat      = r_dat_sync[SYNC_STAGES-1];
  assign w_bck_rise = w_bck & ~r_bck_prev;
  // The first rise after reset only records LRCK, so the partial slot is never captured.
  assign w_lrck_chg = r_lrck_seen & (w_lrck != r_lrck_last);
  assign w_start    = w_bck_rise & w_lrck_chg;
  assign w_store    = r_done & (r_chan | r_left_vld);

  always_ff @(posedge iCLK_18_4 or posedge iRST) begin
    if (iRST) begin
      r_bck_sync  <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
      r_bck_prev  <= 1'b0;
      r_lrck_last <= 1'b0;
      r_lrck_seen <= 1'b0;
    end else begin
      r_bck_sync  <= {r_bck_sync[SYNC_STAGES-2:0], iAUD_BCK};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], iAUD_LRCK};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], iAUD_ADCDAT};
      r_bck_prev  <= w_bck;
      if (w_bck_rise) begin
        r_lrck_last <= w_lrck;
        r_lrck_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK_18_4 or posedge iRST) begin
    if (iRST) begin
      r_state <= StSync;
      r_shift <= '0;
      r_cnt   <= '0;
      r_chan  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_chan  <= w_chan_nxt;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_chan_nxt  = r_chan;
    w_done      = 1'b0;
    w_short     = 1'b0;
    if (w_start) begin
      // An LRCK change always opens a new slot on the same rise, from any state.
      w_short     = (r_state == StShift);
      w_state_nxt = StShift;
      w_chan_nxt  = w_lrck;
      w_shift_nxt = {{(DATA_WIDTH-1){1'b0}}, w_dat};
      w_cnt_nxt   = CntOne;
    end else if (w_bck_rise && (r_state == StShift)) begin
      w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_dat};
      w_cnt_nxt   = r_cnt + CntOne;
      if (w_cnt_nxt == CntFull) begin
        w_done      = 1'b1;
        w_state_nxt = StWait;
      end
    end else if ((r_state != StSync) && (r_state != StShift) && (r_state != StWait)) begin
      w_state_nxt = StSync;
    end
  end

  // Storage runs one cycle after the final bit; r_shift/r_chan are stable in StWait.
  always_ff @(posedge iCLK_18_4 or posedge iRST) begin
    if (iRST) begin
      oLEFT      <= '0;
      oRIGHT     <= '0;
      oVALID     <= 1'b0;
      oFRAME_ERR <= 1'b0;
      r_hold     <= '0;
      r_left_vld <= 1'b0;
    end else begin
      oVALID     <= 1'b0;
      oFRAME_ERR <= w_short;
      if (r_done) begin
        if (r_chan) begin
          r_hold     <= r_shift;
          r_left_vld <= 1'b1;
        end else if (r_left_vld) begin
          oLEFT      <= r_hold;
          oRIGHT     <= r_shift;
          oVALID     <= 1'b1;
          r_left_vld <= 1'b0;
        end
      end
      if (w_short) r_left_vld <= 1'b0;
    end
  end

`ifdef ADIO_RX_PEAK_METER_EN
  logic [DATA_WIDTH-1:0] w_neg, w_mag, r_peak;

  assign w_neg = ~r_shift + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  // Most-negative value has no positive twin; saturate to the largest positive code.
  assign w_mag = !r_shift[DATA_WIDTH-1] ? r_shift :
                 w_neg[DATA_WIDTH-1]    ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : w_neg;

  always_ff @(posedge iCLK_18_4 or posedge iRST) begin
    if (iRST) begin
      r_peak <= '0;
    end else if (iPEAK_CLR) begin
      r_peak <= '0;
    end else if (w_store && (w_mag > r_peak)) begin
      r_peak <= w_mag;
    end
  end

  assign oPEAK = r_peak;
`else
  logic w_unused_peak;
  assign w_unused_peak = iPEAK_CLR ^ w_store;
  assign oPEAK         = '0;
`endif

endmodule

// File: tb/tb_adio_rx.sv
// Directed bench for adio_rx: reset, partial/short/long slots, latency and the optional peak meter.
module tb_adio_rx;

  logic        clk = 1'b0;
  logic        iRST, iAUD_BCK, iAUD_LRCK, iAUD_ADCDAT, iPEAK_CLR;
  logic [15:0] oLEFT, oRIGHT, oPEAK;
  logic        oVALID, oFRAME_ERR;

  int n_vec  = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err   = 0;
  logic [15:0] cap_l = '0;
  logic [15:0] cap_r = '0;
  int v0, e0;

`ifdef ADIO_RX_PEAK_METER_EN
  localparam bit PeakEn = 1'b1;
`else
  localparam bit PeakEn = 1'b0;
`endif

  adio_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .iCLK_18_4  (clk),
    .iRST       (iRST),
    .iAUD_BCK   (iAUD_BCK),
    .iAUD_LRCK  (iAUD_LRCK),
    .iAUD_ADCDAT(iAUD_ADCDAT),
    .iPEAK_CLR  (iPEAK_CLR),
    .oLEFT      (oLEFT),
    .oRIGHT     (oRIGHT),
    .oVALID     (oVALID),
    .oFRAME_ERR (oFRAME_ERR),
    .oPEAK      (oPEAK)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (oVALID) begin
      n_valid++;
      cap_l = oLEFT;
      cap_r = oRIGHT;
    end
    if (oFRAME_ERR) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each call starts and ends 1 time unit after a rising clock edge.
  task automatic send_bit(input logic lr, input logic d);
    iAUD_BCK = 1'b0; iAUD_LRCK = lr; iAUD_ADCDAT = d;
    repeat (6) @(posedge clk);
    #1 iAUD_BCK = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) send_bit(lr, w[15-i]);
      else        send_bit(lr, 1'b1);
    end
  endtask

  initial begin
    iRST = 1'b1; iAUD_BCK = 1'b0; iAUD_LRCK = 1'b1; iAUD_ADCDAT = 1'b0; iPEAK_CLR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_left",  oLEFT, 0);
    check("rst_right", oRIGHT, 0);
    check("rst_valid", oVALID, 0);
    check("rst_ferr",  oFRAME_ERR, 0);
    check("rst_peak",  oPEAK, 0);

    // Release in the middle of a left slot.
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
    iRST = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
    send_slot(1'b0, 16'h1234, 16);
    check("partial_no_valid", n_valid, 0);
    send_slot(1'b1, 16'h5555, 16);
    send_slot(1'b0, 16'hAAAA, 16);
    check("partial_valid_cnt", n_valid, 1);
    check("partial_left",  cap_l, 16'h5555);
    check("partial_right", cap_r, 16'hAAAA);
    check("partial_ferr",  n_err, 0);

    // Basic frame with latency on the final right bit.
    v0 = n_valid;
    send_slot(1'b1, 16'h8001, 16);
    for (int i = 0; i < 15; i++) send_bit(1'b0, 16'h7FFE >> (15 - i) & 1);
    iAUD_BCK = 1'b0; iAUD_ADCDAT = 1'b0;
    repeat (6) @(posedge clk);
    #1 iAUD_BCK = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("lat_valid_early", oVALID, 0);
    @(posedge clk);
    #1 check("lat_valid", oVALID, 1);
    check("basic_left",  oLEFT, 16'h8001);
    check("basic_right", oRIGHT, 16'h7FFE);
    @(posedge clk);
    #1 check("lat_valid_width", oVALID, 0);
    @(posedge clk);
    #1 check("basic_valid_cnt", n_valid - v0, 1);

    // Short left slot.
    v0 = n_valid; e0 = n_err;
    send_slot(1'b1, 16'h5A5A, 10);
    send_slot(1'b0, 16'h00FF, 16);
    check("short_ferr_cnt", n_err - e0, 1);
    check("short_no_valid", n_valid - v0, 0);
    check("short_right_hold", oRIGHT, 16'h7FFE);
    send_slot(1'b1, 16'h0F0F, 16);
    send_slot(1'b0, 16'hF0F0, 16);
    check("short_valid_cnt", n_valid - v0, 1);
    check("short_left",  cap_l, 16'h0F0F);
    check("short_right", cap_r, 16'hF0F0);

    // Long slots with trailing junk bits.
    v0 = n_valid; e0 = n_err;
    send_slot(1'b1, 16'hC3C3, 20);
    send_slot(1'b0, 16'h3C3C, 20);
    check("long_valid_cnt", n_valid - v0, 1);
    check("long_left",  cap_l, 16'hC3C3);
    check("long_right", cap_r, 16'h3C3C);
    check("long_ferr",  n_err - e0, 0);

    // Peak meter (expected values are zero when the feature is not built).
    iPEAK_CLR = 1'b1; @(posedge clk); #1 iPEAK_CLR = 1'b0;
    check("peak_clr0", oPEAK, 0);
    send_slot(1'b1, 16'h0100, 16);
    send_slot(1'b0, 16'hFE00, 16);
    check("peak_pair1", oPEAK, PeakEn ? 32'h0200 : 32'h0);
    send_slot(1'b1, 16'h8000, 16);
    send_slot(1'b0, 16'h0001, 16);
    check("peak_pair2", oPEAK, PeakEn ? 32'h7FFF : 32'h0);
    check("peak_pair2_left",  cap_l, 16'h8000);
    check("peak_pair2_right", cap_r, 16'h0001);
    iPEAK_CLR = 1'b1; @(posedge clk); #1 iPEAK_CLR = 1'b0;
    check("peak_clr1", oPEAK, 0);

    // Reset mid-slot clears outputs without waiting for a clock.
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
    iRST = 1'b1;
    #1;
    check("midrst_left",  oLEFT, 0);
    check("midrst_right", oRIGHT, 0);
    check("midrst_valid", oVALID, 0);
    check("midrst_ferr",  oFRAME_ERR, 0);
    @(posedge clk);
    #1 iRST = 1'b0;
    v0 = n_valid;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    send_slot(1'b0, 16'h1111, 16);
    check("midrst_no_valid", n_valid - v0, 0);
    check("midrst_left_idle", oLEFT, 0);
    send_slot(1'b1, 16'h2222, 16);
    send_slot(1'b0, 16'h3333, 16);
    check("midrst_valid_cnt", n_valid - v0, 1);
    check("midrst_pair_left",  cap_l, 16'h2222);
    check("midrst_pair_right", cap_r, 16'h3333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adio_rx.md
Name: adio_rx

Overview:
- I2S-style audio receiver for the codec ADC path: the capture-side counterpart of the codec DAC serializer.
- Oversamples the codec's BCK, LRCK and ADCDAT pins on the 18.432 MHz system clock and deserializes MSB-first samples.
- Presents each completed left/right sample pair with a one-clock valid pulse to downstream logic (pitch detection, loopback, level display).

Parameters:
- DATA_WIDTH, 16, bits captured per channel per LRCK half-period.
- SYNC_STAGES, 2, flip-flop stages on each serial input (legal range 2..3).

Ports:
- iCLK_18_4  input  1  system clock, 18.432 MHz; all logic on rising edge.
- iRST  input  1  reset, asynchronous assert, active-high.
- iAUD_BCK  input  1  bit clock from the codec; asynchronous to iCLK_18_4; nominal period 12 iCLK_18_4 cycles.
- iAUD_LRCK  input  1  channel select; 1 = left, 0 = right.
- iAUD_ADCDAT  input  1  serial ADC data, MSB first.
- iPEAK_CLR  input  1  clears the peak meter (optional feature).
- oLEFT  output  DATA_WIDTH  last complete left sample.
- oRIGHT  output  DATA_WIDTH  last complete right sample.
- oVALID  output  1  one-cycle pulse when a new L/R pair is on oLEFT/oRIGHT.
- oFRAME_ERR  output  1  one-cycle pulse when a channel slot ends short.
- oPEAK  output  DATA_WIDTH  peak absolute level (optional feature).

Behaviour:
- Input synchronization:
  - BCK, LRCK and ADCDAT each pass through SYNC_STAGES flops.
  - BCK rise = synced BCK 1 now and 0 on the previous cycle.
  - All sampling happens only on a BCK rise; LRCK and ADCDAT use the same synchronized cycle.
- Reset:
  - oLEFT = 0, oRIGHT = 0, oVALID = 0, oFRAME_ERR = 0, oPEAK = 0.
  - Shift register, bit counter and held left word = 0; FSM = SYNC.
- FSM:
  - SYNC: wait for a BCK rise where sampled LRCK differs from the LRCK held at the previous BCK rise. This discards the partial slot after reset. On that rise, go to SHIFT, latch the channel from LRCK, and capture ADCDAT as bit DATA_WIDTH-1 (count = 1).
  - SHIFT: each BCK rise shifts ADCDAT in at the LSB and increments the count. When the count reaches DATA_WIDTH, store the word and go to WAIT.
  - WAIT: ignore further BCK rises until an LRCK change; then go to SHIFT, capturing the first bit of the new slot on that same rise.
- Word storage:
  - A left word goes into an internal hold register.
  - A right word updates oRIGHT, copies the hold register into oLEFT, and pulses oVALID.
  - oVALID pulses only if a left word was stored since the last pulse; a right word without a preceding left updates nothing.
- Latency: oVALID rises on the cycle after the BCK rise that carries the right LSB, i.e. SYNC_STAGES+2 iCLK_18_4 cycles after the pin edge. oLEFT and oRIGHT are stable from that cycle until the next pulse.
- Short slot:
  - Trigger: LRCK changes while in SHIFT with count < DATA_WIDTH.
  - Partial word is discarded and the held left word invalidated.
  - oFRAME_ERR pulses once.
  - The new slot starts capture on that same BCK rise (no return to SYNC).
- Long slot: extra bits are ignored in WAIT. This is not an error.
- Data arithmetic: samples are two's complement; no sign extension or scaling.
- Reset mid-operation: asserted at any point it clears everything immediately. After release, the FSM re-enters SYNC and the first pair out is fully captured after release.

Optional Feature:
- Macro: ADIO_RX_PEAK_METER_EN.
- Defined:
  - Each stored word (either channel) takes its magnitude; 0x8000 maps to 0x7FFF.
  - If the magnitude exceeds oPEAK, oPEAK updates on the storage cycle.
  - iPEAK_CLR forces oPEAK = 0 next cycle and has priority over a same-cycle update.
- Not defined: oPEAK tied to 0; iPEAK_CLR ignored; no peak logic synthesized.

Test Plan:
- Reset check:
  - Stimulus: assert iRST mid-run.
  - Response: all outputs 0 within the same cycle; no oVALID until a full L then R slot completes after release.
- Basic frame:
  - Stimulus: after sync, send L = 0x8001, R = 0x7FFE (BCK period 12 clk, 16 bits per slot).
  - Response: one oVALID pulse; oLEFT = 0x8001, oRIGHT = 0x7FFE; pulse 4 clk after the right LSB BCK rise.
- Partial slot after reset:
  - Stimulus: release iRST mid-left-slot, then full R = 0x1234, L = 0x5555, R = 0xAAAA.
  - Response: no oVALID for 0x1234; first pulse gives 0x5555 / 0xAAAA.
- Short slot:
  - Stimulus: left slot with only 10 bits, then full R = 0x00FF.
  - Response: one oFRAME_ERR pulse; no oVALID; next full L = 0x0F0F, R = 0xF0F0 gives oVALID with those values.
- Long slot:
  - Stimulus: 20 BCKs per slot carrying L = 0xC3C3 plus 4 junk bits, R = 0x3C3C.
  - Response: oLEFT = 0xC3C3, oRIGHT = 0x3C3C; oFRAME_ERR stays 0.
- Peak meter (ADIO_RX_PEAK_METER_EN defined):
  - Stimulus: pairs (0x0100, 0xFE00), then (0x8000, 0x0001), then iPEAK_CLR.
  - Response: oPEAK 0x0200, then 0x7FFF, then 0.
